// File: rtl/elevator_scan_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_scan_ctrl
//
// Multi-request elevator car controller. Hall and car calls are latched into a
// pending-request bitmap. They are served in SCAN order: the car keeps
// sweeping in one direction while requests remain ahead of it, and reverses
// only when the sweep runs out. Travel between floors and the door dwell are
// timed. A level-sensitive emergency stop freezes the car in place and keeps
// the latched requests.
//
// Ports
//   clk            : single clock, all logic on the rising edge
//   reset          : synchronous, active-high reset
//   call_valid     : one-cycle call strobe
//   call_floor     : requested floor, sampled while call_valid is high
//   emergency_stop : level; high halts the car
//   current_floor  : floor the car is at, or the floor it last passed
//   direction      : 2'b00 idle, 2'b01 up, 2'b10 down
//   moving         : high while the car travels between floors
//   door           : high while the door is open
//   pending        : outstanding request bitmap, one bit per floor
//   call_error     : one-cycle pulse when a call names a nonexistent floor
// -----------------------------------------------------------------------------
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic                  emergency_stop,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [1:0]            direction,
  output logic                  moving,
  output logic                  door,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  call_error
);

  localparam int STEP_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [STEP_W-1:0]  STEP_LAST   = STEP_W'(MOVE_CYCLES - 1);
  localparam logic [DOOR_W-1:0]  DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  // One bit wider than a floor index so the range check stays meaningful
  // when NUM_FLOORS == 2**FLOOR_W.
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN,
    S_EMERGENCY
  } state_t;

  // Outcome of the SCAN decision taken at a floor: where to go next.
  typedef struct packed {
    state_t     st;
    logic [1:0] dir;
  } sched_t;

  // ---------------------------------------------------------------------------
  // Floor mask helpers
  // ---------------------------------------------------------------------------
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    floor_bit = '0;
    for (int i = 0; i < NUM_FLOORS; i++) floor_bit[i] = (i == int'(f));
  endfunction

  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    above_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) above_mask[i] = (i > int'(f));
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) below_mask[i] = (i < int'(f));
  endfunction

  // SCAN decision: keep going the way we were heading while there is work
  // ahead, otherwise turn around, otherwise go idle. With no heading (idle)
  // the up side is preferred.
  function automatic sched_t schedule(input logic [FLOOR_W-1:0]    f,
                                      input logic [1:0]            dir,
                                      input logic [NUM_FLOORS-1:0] reqs);
    logic any_up;
    logic any_dn;
    any_up   = |(reqs & above_mask(f));
    any_dn   = |(reqs & below_mask(f));
    schedule = '{st: S_IDLE, dir: DIR_IDLE};
    if (dir == DIR_DOWN) begin
      if (any_dn)      schedule = '{st: S_MOVE_DOWN, dir: DIR_DOWN};
      else if (any_up) schedule = '{st: S_MOVE_UP,   dir: DIR_UP};
    end else begin
      if (any_up)      schedule = '{st: S_MOVE_UP,   dir: DIR_UP};
      else if (any_dn) schedule = '{st: S_MOVE_DOWN, dir: DIR_DOWN};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state;
  logic [STEP_W-1:0]   step_cnt;
  logic [DOOR_W-1:0]   door_cnt;

  state_t              state_d;
  logic [FLOOR_W-1:0]  floor_d;
  logic [1:0]          dir_d;
  logic [STEP_W-1:0]   step_d;
  logic [DOOR_W-1:0]   door_d;
  logic [NUM_FLOORS-1:0] pending_d;

  // ---------------------------------------------------------------------------
  // Call decode
  // ---------------------------------------------------------------------------
  logic                  call_in_range;
  logic                  call_ok;
  logic                  call_here;     // call for the floor the car stands at
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] pend_set;      // pending including this cycle's call
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [FLOOR_W-1:0]    floor_step;    // floor reached at the end of a step
  sched_t                sched_idle;
  sched_t                sched_arrive;
  sched_t                sched_door;

  // NOTE: every signal driven from always_comb gets a default at the top of
  // the block, so no path through the branches leaves it unassigned and no
  // latch is inferred.
  always_comb begin
    call_in_range = ({1'b0, call_floor} < FLOOR_LIMIT);
    call_ok       = call_valid && call_in_range;
    call_here     = call_ok && (call_floor == current_floor) &&
                    ((state == S_IDLE) || (state == S_DOOR_OPEN));
    set_mask      = '0;
    if (call_ok && !call_here) set_mask = floor_bit(call_floor);
    pend_set      = pending | set_mask;

    // Clamp at the shaft ends; the scheduler never heads past them anyway.
    if (state == S_MOVE_DOWN)
      floor_step = (current_floor == '0) ? current_floor
                                         : current_floor - FLOOR_W'(1);
    else
      floor_step = (current_floor == TOP_FLOOR) ? current_floor
                                                : current_floor + FLOOR_W'(1);

    // Leaving IDLE looks only at registered requests, so a call costs one
    // cycle to latch before the car reacts. Decisions on arrival and at door
    // close include a same-cycle call so it is never missed.
    sched_idle   = schedule(current_floor, DIR_IDLE, pending);
    sched_arrive = schedule(floor_step, direction, pend_set);
    sched_door   = schedule(current_floor, direction, pend_set);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state;
    floor_d    = current_floor;
    dir_d      = direction;
    step_d     = step_cnt;
    door_d     = door_cnt;
    clear_mask = '0;

    case (state)
      S_IDLE: begin
        if (call_here) begin
          state_d = S_DOOR_OPEN;
          door_d  = '0;
        end else if (|(pending & floor_bit(current_floor))) begin
          // A request for this floor latched while moving past or while
          // halted; serve it here rather than driving away from it.
          clear_mask = floor_bit(current_floor);
          state_d    = S_DOOR_OPEN;
          door_d     = '0;
        end else if (|pending) begin
          state_d = sched_idle.st;
          dir_d   = sched_idle.dir;
          step_d  = '0;
        end
      end

      S_MOVE_UP, S_MOVE_DOWN: begin
        if (step_cnt == STEP_LAST) begin
          floor_d = floor_step;
          step_d  = '0;
          if (|(pend_set & floor_bit(floor_step))) begin
            // Clearing after the set means a call that lands on the arrival
            // edge for this same floor is absorbed by the stop.
            clear_mask = floor_bit(floor_step);
            state_d    = S_DOOR_OPEN;
            door_d     = '0;
          end else begin
            state_d = sched_arrive.st;
            dir_d   = sched_arrive.dir;
          end
        end else begin
          step_d = step_cnt + STEP_W'(1);
        end
      end

      S_DOOR_OPEN: begin
        if (call_here) begin
          door_d = '0;
        end else if (door_cnt == DOOR_LAST) begin
          door_d  = '0;
          step_d  = '0;
          state_d = sched_door.st;
          dir_d   = sched_door.dir;
        end else begin
          door_d = door_cnt + DOOR_W'(1);
        end
      end

      S_EMERGENCY: begin
        if (!emergency_stop) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        dir_d   = DIR_IDLE;
      end
    endcase

    // Emergency overrides every transition above. The partial step is
    // dropped, so after release the car repeats the whole step.
    if (emergency_stop) begin
      state_d    = S_EMERGENCY;
      floor_d    = current_floor;
      dir_d      = DIR_IDLE;
      step_d     = '0;
      door_d     = '0;
      clear_mask = '0;
    end

    pending_d = pend_set & ~clear_mask;
  end

  // ---------------------------------------------------------------------------
  // Registers. Outputs are decoded from the next state so they are registered
  // and line up with the state they describe.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      current_floor <= '0;
      direction     <= DIR_IDLE;
      step_cnt      <= '0;
      door_cnt      <= '0;
      pending       <= '0;
      moving        <= 1'b0;
      door          <= 1'b0;
      call_error    <= 1'b0;
    end else begin
      state         <= state_d;
      current_floor <= floor_d;
      direction     <= dir_d;
      step_cnt      <= step_d;
      door_cnt      <= door_d;
      pending       <= pending_d;
      moving        <= (state_d == S_MOVE_UP) || (state_d == S_MOVE_DOWN);
      door          <= (state_d == S_DOOR_OPEN);
      call_error    <= call_valid && !call_in_range;
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_scan_ctrl
//
// Scoreboard bench for elevator_scan_ctrl (6 floors, 4-cycle steps, 6-cycle
// door dwell). Each stimulus step pushes the hand-derived output snapshots it
// expects, tagged with the clock edge at which they must appear. A monitor
// samples the outputs on every falling edge. Whenever any output changes, it
// pops the next expectation and compares both the edge number and the full
// output snapshot.
// -----------------------------------------------------------------------------
module tb_elevator_scan_ctrl;

  localparam int NUM_FLOORS  = 6;
  localparam int FLOOR_W     = 3;
  localparam int MOVE_CYCLES = 4;
  localparam int DOOR_CYCLES = 6;

  localparam logic [1:0] D_IDLE = 2'b00;
  localparam logic [1:0] D_UP   = 2'b01;
  localparam logic [1:0] D_DN   = 2'b10;

  logic                  clk;
  logic                  reset;
  logic                  call_valid;
  logic [FLOOR_W-1:0]    call_floor;
  logic                  emergency_stop;
  logic [FLOOR_W-1:0]    current_floor;
  logic [1:0]            direction;
  logic                  moving;
  logic                  door;
  logic [NUM_FLOORS-1:0] pending;
  logic                  call_error;

  elevator_scan_ctrl #(
    .NUM_FLOORS  (NUM_FLOORS),
    .FLOOR_W     (FLOOR_W),
    .MOVE_CYCLES (MOVE_CYCLES),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .call_valid     (call_valid),
    .call_floor     (call_floor),
    .emergency_stop (emergency_stop),
    .current_floor  (current_floor),
    .direction      (direction),
    .moving         (moving),
    .door           (door),
    .pending        (pending),
    .call_error     (call_error)
  );

  typedef struct packed {
    logic [FLOOR_W-1:0]    floor;
    logic [1:0]            dir;
    logic                  mov;
    logic                  door;
    logic [NUM_FLOORS-1:0] pend;
    logic                  err;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t  exp_q[$];
  snap_t e;          // running expected output snapshot
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  bit    mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned expv);
    n_checks++;
    if (act !== expv)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, expv, cyc);
    else
      n_pass++;
  endtask

  function automatic snap_t sample();
    sample = '{floor: current_floor, dir: direction, mov: moving,
               door: door, pend: pending, err: call_error};
  endfunction

  task automatic push(input int c);
    exp_q.push_back('{cyc: c, s: e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Drives a call for one cycle; e_cyc is the edge that samples it.
  task automatic call(input int f, output int e_cyc);
    call_valid = 1'b1;
    call_floor = FLOOR_W'(f);
    e_cyc      = cyc + 1;
    tick();
    call_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare on every output change
  // ---------------------------------------------------------------------------
  initial begin
    snap_t prev;
    snap_t cur;
    exp_t  x;
    wait (mon_en);
    @(negedge clk);
    prev = sample();
    forever begin
      @(negedge clk);
      cur = sample();
      if (cur != prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_change: got 0x%0h at edge %0d, no change expected",
                   cur, cyc);
        end else begin
          x = exp_q.pop_front();
          check("change_edge", longint'(cyc), longint'(x.cyc));
          check("outputs", longint'(cur), longint'(x.s));
        end
      end
      prev = cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t;
    int t2;
    reset          = 1'b1;
    call_valid     = 1'b0;
    call_floor     = '0;
    emergency_stop = 1'b0;
    e              = '0;
    tick();
    tick();
    reset = 1'b0;

    check("reset_floor",     current_floor, 0);
    check("reset_direction", direction, 0);
    check("reset_moving",    moving, 0);
    check("reset_door",      door, 0);
    check("reset_pending",   pending, 0);
    check("reset_error",     call_error, 0);
    mon_en = 1'b1;
    tick();
    tick();

    // 1: floor 0 -> 3, no intermediate stops
    call(3, t);
    e.pend = 6'b001000; push(t);
    e.dir = D_UP; e.mov = 1'b1; push(t + 1);
    e.floor = 3'd1; push(t + 5);
    e.floor = 3'd2; push(t + 9);
    e.floor = 3'd3; e.mov = 1'b0; e.door = 1'b1; e.pend = '0; push(t + 13);
    e.dir = D_IDLE; e.door = 1'b0; push(t + 19);
    wait_cyc(t + 22);

    // Return to floor 0
    call(0, t);
    e.pend = 6'b000001; push(t);
    e.dir = D_DN; e.mov = 1'b1; push(t + 1);
    e.floor = 3'd2; push(t + 5);
    e.floor = 3'd1; push(t + 9);
    e.floor = 3'd0; e.mov = 1'b0; e.door = 1'b1; e.pend = '0; push(t + 13);
    e.dir = D_IDLE; e.door = 1'b0; push(t + 19);
    wait_cyc(t + 22);

    // 2: calls 4 then 2 on consecutive cycles; stop at 2 then 4, heading up
    call(4, t);
    e.pend = 6'b010000; push(t);
    call(2, t2);
    e.dir = D_UP; e.mov = 1'b1; e.pend = 6'b010100; push(t + 1);
    e.floor = 3'd1; push(t + 5);
    e.floor = 3'd2; e.mov = 1'b0; e.door = 1'b1; e.pend = 6'b010000; push(t + 9);
    e.mov = 1'b1; e.door = 1'b0; push(t + 15);
    e.floor = 3'd3; push(t + 19);
    e.floor = 3'd4; e.mov = 1'b0; e.door = 1'b1; e.pend = '0; push(t + 23);
    e.dir = D_IDLE; e.door = 1'b0; push(t + 29);
    wait_cyc(t + 32);

    // Move down to floor 2
    call(2, t);
    e.pend = 6'b000100; push(t);
    e.dir = D_DN; e.mov = 1'b1; push(t + 1);
    e.floor = 3'd3; push(t + 5);
    e.floor = 3'd2; e.mov = 1'b0; e.door = 1'b1; e.pend = '0; push(t + 9);
    e.dir = D_IDLE; e.door = 1'b0; push(t + 15);
    wait_cyc(t + 18);

    // 3: heading to 5, call 1 behind; finish sweep, reverse, stop at 1
    call(5, t);
    e.pend = 6'b100000; push(t);
    e.dir = D_UP; e.mov = 1'b1; push(t + 1);
    tick();
    call(1, t2);
    e.pend = 6'b100010; push(t + 2);
    e.floor = 3'd3; push(t + 5);
    e.floor = 3'd4; push(t + 9);
    e.floor = 3'd5; e.mov = 1'b0; e.door = 1'b1; e.pend = 6'b000010; push(t + 13);
    e.dir = D_DN; e.mov = 1'b1; e.door = 1'b0; push(t + 19);
    e.floor = 3'd4; push(t + 23);
    e.floor = 3'd3; push(t + 27);
    e.floor = 3'd2; push(t + 31);
    e.floor = 3'd1; e.mov = 1'b0; e.door = 1'b1; e.pend = '0; push(t + 35);
    e.dir = D_IDLE; e.door = 1'b0; push(t + 41);
    wait_cyc(t + 44);

    // 4: emergency 2 cycles into the 1->2 step, held 5 edges; a call
    //    during the halt still latches; the step restarts in full
    call(2, t);
    e.pend = 6'b000100; push(t);
    e.dir = D_UP; e.mov = 1'b1; push(t + 1);
    e.dir = D_IDLE; e.mov = 1'b0; push(t + 3);
    e.pend = 6'b010100; push(t + 5);
    e.dir = D_UP; e.mov = 1'b1; push(t + 9);
    e.floor = 3'd2; e.mov = 1'b0; e.door = 1'b1; e.pend = 6'b010000; push(t + 13);
    e.mov = 1'b1; e.door = 1'b0; push(t + 19);
    e.floor = 3'd3; push(t + 23);
    e.floor = 3'd4; e.mov = 1'b0; e.door = 1'b1; e.pend = '0; push(t + 27);
    e.dir = D_IDLE; e.door = 1'b0; push(t + 33);
    tick();
    tick();
    emergency_stop = 1'b1;
    tick();
    tick();
    call(4, t2);
    tick();
    tick();
    emergency_stop = 1'b0;
    wait_cyc(t + 36);

    // 5: out-of-range calls pulse call_error; same-floor call restarts dwell
    call(6, t);
    e.err = 1'b1; push(t);
    e.err = 1'b0; push(t + 1);
    tick();
    tick();
    call(4, t);
    e.door = 1'b1; push(t);
    call(7, t2);
    e.err = 1'b1; push(t + 1);
    e.err = 1'b0; push(t + 2);
    tick();
    call(4, t2);
    e.door = 1'b0; push(t + 9);
    wait_cyc(t + 12);

    // 6: reset in the middle of a step at floor 3 with a request pending
    call(0, t);
    e.pend = 6'b000001; push(t);
    e.dir = D_DN; e.mov = 1'b1; push(t + 1);
    e.floor = 3'd3; push(t + 5);
    e = '0; push(t + 7);
    wait_cyc(t + 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_cyc(t + 10);

    // 7: call lands on the arrival edge at floor 2; one stop, bit ends clear
    call(3, t);
    e.pend = 6'b001000; push(t);
    e.dir = D_UP; e.mov = 1'b1; push(t + 1);
    e.floor = 3'd1; push(t + 5);
    e.floor = 3'd2; e.mov = 1'b0; e.door = 1'b1; push(t + 9);
    e.mov = 1'b1; e.door = 1'b0; push(t + 15);
    e.floor = 3'd3; e.mov = 1'b0; e.door = 1'b1; e.pend = '0; push(t + 19);
    e.dir = D_IDLE; e.door = 1'b0; push(t + 25);
    wait_cyc(t + 8);
    call(2, t2);
    wait_cyc(t + 35);

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    check("outstanding_expectations", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
